// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one RV32I ALU between two requesters. Port 0 is the execute stage
//   and port 1 is the branch/address-compare path. A granted order is driven
//   to the ALU for exactly one cycle. The ALU result and zero flag are then
//   registered and returned to the granted port over a valid/ready channel.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/ready            request handshake (ready is combinational)
//   reqN_order, reqN_a, reqN_b  decoded ALU order and operands
//   rspN_valid/ready            response handshake
//   rspN_result, rspN_zero      registered ALU result and zero flag
//   alu_order, alu_a, alu_b     drive to the shared ALU (registered)
//   alu_result, alu_zero        combinational ALU outputs
//   busy                        high whenever the FSM is not IDLE
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no operation in flight; arbitrate incoming requests
// EXEC  | ALU driven from latched order/operands; capture at edge
// RESP  | result held on granted port until its rsp_ready
module alu_share_arbiter #(
  parameter int                   DATA_W     = 32,
  parameter int                   ORDER_W    = 4,
  parameter logic [ORDER_W-1:0]   IDLE_ORDER = '0,
  parameter bit                   FIXED_PRIO = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [ORDER_W-1:0] req0_order,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [ORDER_W-1:0] req1_order,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic [DATA_W-1:0]  rsp0_result,
  output logic               rsp0_zero,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [DATA_W-1:0]  rsp1_result,
  output logic               rsp1_zero,
  output logic [ORDER_W-1:0] alu_order,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_zero,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  logic   last_grant;
  logic   grant_id;
  logic   rsp_hs;
  logic   arb_en;
  logic   pick1;
  logic   req_hs;

  always_comb begin
    rsp_hs = (state == RESP) && (grant_id ? rsp1_ready : rsp0_ready);
    // Re-arbitration happens in IDLE and in the same cycle a response is taken,
    // which gives one op per two cycles when responses are never stalled.
    arb_en = (state == IDLE) || rsp_hs;
    if (FIXED_PRIO)
      pick1 = req1_valid && !req0_valid;
    else
      pick1 = req1_valid && (!req0_valid || !last_grant);
    req0_ready = arb_en && req0_valid && !pick1;
    req1_ready = arb_en && req1_valid && pick1;
    req_hs     = req0_ready || req1_ready;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      grant_id    <= 1'b0;
      alu_order   <= IDLE_ORDER;
      alu_a       <= '0;
      alu_b       <= '0;
      rsp0_valid  <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp1_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp1_zero   <= 1'b0;
    end else begin
      // alu_order is only non-idle in the single cycle after an accept;
      // operands keep their last value so the ALU inputs do not toggle.
      alu_order <= IDLE_ORDER;
      if (req_hs) begin
        grant_id   <= req1_ready;
        last_grant <= req1_ready;
        alu_order  <= req1_ready ? req1_order : req0_order;
        alu_a      <= req1_ready ? req1_a : req0_a;
        alu_b      <= req1_ready ? req1_b : req0_b;
      end

      case (state)
        IDLE: begin
          if (req_hs) state <= EXEC;
        end
        EXEC: begin
          if (grant_id) begin
            rsp1_result <= alu_result;
            rsp1_zero   <= alu_zero;
            rsp1_valid  <= 1'b1;
          end else begin
            rsp0_result <= alu_result;
            rsp0_zero   <= alu_zero;
            rsp0_valid  <= 1'b1;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_hs) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            state      <= req_hs ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  localparam logic [3:0] ORD_AND  = 4'b0000;
  localparam logic [3:0] ORD_OR   = 4'b0001;
  localparam logic [3:0] ORD_ADD  = 4'b0010;
  localparam logic [3:0] ORD_SUB  = 4'b0110;
  localparam logic [3:0] IDLE_ORD = 4'b0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_order = '0, req1_order = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_result, rsp1_result;
  logic        rsp0_zero, rsp1_zero;
  logic [3:0]  alu_order;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero, busy;

  logic        fp_req0_valid = 1'b0, fp_req1_valid = 1'b0;
  logic        fp_req0_ready, fp_req1_ready;
  logic [3:0]  fp_req0_order = '0, fp_req1_order = '0;
  logic [31:0] fp_req0_a = '0, fp_req0_b = '0, fp_req1_a = '0, fp_req1_b = '0;
  logic        fp_rsp0_valid, fp_rsp1_valid;
  logic        fp_rsp0_ready = 1'b1, fp_rsp1_ready = 1'b1;
  logic [31:0] fp_rsp0_result, fp_rsp1_result;
  logic        fp_rsp0_zero, fp_rsp1_zero;
  logic [3:0]  fp_alu_order;
  logic [31:0] fp_alu_a, fp_alu_b, fp_alu_result;
  logic        fp_alu_zero, fp_busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        port;
    logic [31:0] result;
    logic        zero;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [31:0] alu_fn(input logic [3:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    case (o)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_result    = alu_fn(alu_order, alu_a, alu_b);
  assign alu_zero      = (alu_result == 32'd0);
  assign fp_alu_result = alu_fn(fp_alu_order, fp_alu_a, fp_alu_b);
  assign fp_alu_zero   = (fp_alu_result == 32'd0);

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(32), .ORDER_W(4), .IDLE_ORDER(IDLE_ORD), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_order(req0_order),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_order(req1_order),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero),
    .alu_order(alu_order), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .busy(busy)
  );

  alu_share_arbiter #(.DATA_W(32), .ORDER_W(4), .IDLE_ORDER(IDLE_ORD), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(fp_req0_valid), .req0_ready(fp_req0_ready), .req0_order(fp_req0_order),
    .req0_a(fp_req0_a), .req0_b(fp_req0_b),
    .req1_valid(fp_req1_valid), .req1_ready(fp_req1_ready), .req1_order(fp_req1_order),
    .req1_a(fp_req1_a), .req1_b(fp_req1_b),
    .rsp0_valid(fp_rsp0_valid), .rsp0_ready(fp_rsp0_ready), .rsp0_result(fp_rsp0_result),
    .rsp0_zero(fp_rsp0_zero),
    .rsp1_valid(fp_rsp1_valid), .rsp1_ready(fp_rsp1_ready), .rsp1_result(fp_rsp1_result),
    .rsp1_zero(fp_rsp1_zero),
    .alu_order(fp_alu_order), .alu_a(fp_alu_a), .alu_b(fp_alu_b),
    .alu_result(fp_alu_result), .alu_zero(fp_alu_zero), .busy(fp_busy)
  );

  // Scoreboard: push on request handshake, pop on response handshake.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n) begin
      if (req0_valid && req0_ready) begin
        e.port = 1'b0; e.result = alu_fn(req0_order, req0_a, req0_b);
        e.zero = (e.result == 32'd0); exp_q.push_back(e);
      end
      if (req1_valid && req1_ready) begin
        e.port = 1'b1; e.result = alu_fn(req1_order, req1_a, req1_b);
        e.zero = (e.result == 32'd0); exp_q.push_back(e);
      end
      if (req0_valid && req1_valid) begin
        n_checks++;
        if ((req0_ready && req1_ready) !== 1'b0)
          $display("FAIL both_ready: got r0=%b r1=%b, want not both", req0_ready, req1_ready);
        else n_pass++;
      end
      if (rsp0_valid && rsp0_ready) begin
        n_checks++;
        if (exp_q.size() == 0)
          $display("FAIL sb_rsp0: got result %0d with no request outstanding", rsp0_result);
        else begin
          e = exp_q.pop_front();
          if ({1'b0, rsp0_result, rsp0_zero} !== {e.port, e.result, e.zero})
            $display("FAIL sb_rsp0: got port 0 result %0d zero %b, want port %0d result %0d zero %b",
                     rsp0_result, rsp0_zero, e.port, e.result, e.zero);
          else n_pass++;
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        n_checks++;
        if (exp_q.size() == 0)
          $display("FAIL sb_rsp1: got result %0d with no request outstanding", rsp1_result);
        else begin
          e = exp_q.pop_front();
          if ({1'b1, rsp1_result, rsp1_zero} !== {e.port, e.result, e.zero})
            $display("FAIL sb_rsp1: got port 1 result %0d zero %b, want port %0d result %0d zero %b",
                     rsp1_result, rsp1_zero, e.port, e.result, e.zero);
          else n_pass++;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    #1;
    n_checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy} !== 5'b0)
      $display("FAIL reset_flags: got %b, want 00000",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy});
    else n_pass++;
    n_checks++;
    if (alu_order !== IDLE_ORD)
      $display("FAIL reset_alu_order: got %b, want %b", alu_order, IDLE_ORD);
    else n_pass++;
    n_checks++;
    if ({alu_a, alu_b} !== 64'd0)
      $display("FAIL reset_alu_ops: got a=%0d b=%0d, want 0 0", alu_a, alu_b);
    else n_pass++;
    n_checks++;
    if ({rsp0_result, rsp1_result, rsp0_zero, rsp1_zero} !== 66'd0)
      $display("FAIL reset_rsp_regs: got %0d %0d %b %b, want zeros",
               rsp0_result, rsp1_result, rsp0_zero, rsp1_zero);
    else n_pass++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick();
    req0_valid = 1'b1; req0_order = ORD_ADD; req0_a = 32'd5; req0_b = 32'd7;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL single_ready: got %b, want 10", {req0_ready, req1_ready});
    else n_pass++;
    tick();
    req0_valid = 1'b0;
    #1;
    n_checks++;
    if ({alu_order, alu_a, alu_b, busy} !== {ORD_ADD, 32'd5, 32'd7, 1'b1})
      $display("FAIL single_exec: got order %b a %0d b %0d busy %b, want %b 5 7 1",
               alu_order, alu_a, alu_b, busy, ORD_ADD);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if ({rsp0_valid, rsp0_result, rsp0_zero, rsp1_valid} !== {1'b1, 32'd12, 1'b0, 1'b0})
      $display("FAIL single_rsp: got v0 %b res %0d z %b v1 %b, want 1 12 0 0",
               rsp0_valid, rsp0_result, rsp0_zero, rsp1_valid);
    else n_pass++;
    n_checks++;
    if (alu_order !== IDLE_ORD)
      $display("FAIL single_resp_order: got %b, want %b", alu_order, IDLE_ORD);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if ({rsp0_valid, busy, alu_order, alu_a} !== {1'b0, 1'b0, IDLE_ORD, 32'd5})
      $display("FAIL single_after: got v0 %b busy %b order %b a %0d, want 0 0 %b 5",
               rsp0_valid, busy, alu_order, alu_a, IDLE_ORD);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0]  o0 [2];
    logic [31:0] a0 [2], b0 [2], a1 [2], b1 [2];
    logic [3:0]  o1 [2];
    int idx0, idx1, cyc;
    int seq[$];
    logic h0, h1;
    o0[0] = ORD_SUB; a0[0] = 32'd9;  b0[0] = 32'd9;
    o0[1] = ORD_ADD; a0[1] = 32'd10; b0[1] = 32'd20;
    o1[0] = ORD_ADD; a1[0] = 32'd1;  b1[0] = 32'd2;
    o1[1] = ORD_SUB; a1[1] = 32'd50; b1[1] = 32'd8;
    idx0 = 0; idx1 = 0; cyc = 0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick();
    req0_valid = 1'b1; req0_order = o0[0]; req0_a = a0[0]; req0_b = b0[0];
    req1_valid = 1'b1; req1_order = o1[0]; req1_a = a1[0]; req1_b = b1[0];
    while (cyc < 40 && seq.size() < 4) begin
      #1;
      h0 = req0_valid && req0_ready;
      h1 = req1_valid && req1_ready;
      tick();
      cyc++;
      if (h0) begin
        seq.push_back(0); idx0++;
        if (idx0 < 2) begin req0_order = o0[idx0]; req0_a = a0[idx0]; req0_b = b0[idx0]; end
        else req0_valid = 1'b0;
      end
      if (h1) begin
        seq.push_back(1); idx1++;
        if (idx1 < 2) begin req1_order = o1[idx1]; req1_a = a1[idx1]; req1_b = b1[idx1]; end
        else req1_valid = 1'b0;
      end
    end
    n_checks++;
    if (seq.size() !== 4)
      $display("FAIL rr_count: got %0d grants, want 4 (cycle budget)", seq.size());
    else n_pass++;
    for (int i = 0; i < seq.size(); i++) begin
      n_checks++;
      if (seq[i] !== (i % 2))
        $display("FAIL rr_order[%0d]: got port %0d, want port %0d", i, seq[i], i % 2);
      else n_pass++;
    end
    repeat (4) tick();
  endtask

  task automatic test_backpressure();
    int w;
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    tick();
    req0_valid = 1'b1; req0_order = ORD_ADD; req0_a = 32'd3; req0_b = 32'd4;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_order = ORD_OR; req1_a = 32'd12; req1_b = 32'd3;
    w = 0;
    #1;
    while (!rsp0_valid && w < 10) begin tick(); #1; w++; end
    n_checks++;
    if (rsp0_valid !== 1'b1)
      $display("FAIL bp_wait: got rsp0_valid %b after %0d cycles, want 1", rsp0_valid, w);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin tick(); #1; end
      n_checks++;
      if ({rsp0_valid, rsp0_result, rsp0_zero, busy, req1_ready} !== {1'b1, 32'd7, 1'b0, 1'b1, 1'b0})
        $display("FAIL bp_hold[%0d]: got v0 %b res %0d z %b busy %b r1 %b, want 1 7 0 1 0",
                 i, rsp0_valid, rsp0_result, rsp0_zero, busy, req1_ready);
      else n_pass++;
    end
    tick();
    rsp0_ready = 1'b1;
    #1;
    n_checks++;
    if ({req1_ready, rsp0_valid} !== 2'b11)
      $display("FAIL bp_release: got r1 %b v0 %b, want 1 1", req1_ready, rsp0_valid);
    else n_pass++;
    tick();
    req1_valid = 1'b0;
    #1;
    n_checks++;
    if ({rsp0_valid, busy} !== 2'b01)
      $display("FAIL bp_after: got v0 %b busy %b, want 0 1", rsp0_valid, busy);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if ({rsp1_valid, rsp1_result} !== {1'b1, 32'd15})
      $display("FAIL bp_rsp1: got v1 %b res %0d, want 1 15", rsp1_valid, rsp1_result);
    else n_pass++;
    repeat (3) tick();
  endtask

  task automatic test_req_pulse();
    int w;
    rsp0_ready = 1'b0; rsp1_ready = 1'b1;
    tick();
    req0_valid = 1'b1; req0_order = ORD_AND; req0_a = 32'd12; req0_b = 32'd10;
    tick();
    req0_valid = 1'b0;
    w = 0;
    #1;
    while (!rsp0_valid && w < 10) begin tick(); #1; w++; end
    tick();
    req1_valid = 1'b1; req1_order = ORD_ADD; req1_a = 32'd100; req1_b = 32'd1;
    #1;
    n_checks++;
    if ({req1_ready, rsp0_valid, rsp0_result} !== {1'b0, 1'b1, 32'd8})
      $display("FAIL pulse_ready: got r1 %b v0 %b res %0d, want 0 1 8",
               req1_ready, rsp0_valid, rsp0_result);
    else n_pass++;
    tick();
    req1_valid = 1'b0; rsp0_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      n_checks++;
      if ({rsp1_valid, req1_ready, busy} !== 3'b000)
        $display("FAIL pulse_no_grant[%0d]: got v1 %b r1 %b busy %b, want 0 0 0",
                 i, rsp1_valid, req1_ready, busy);
      else n_pass++;
    end
  endtask

  task automatic test_fixed_prio();
    logic [3:0]  ops [3];
    logic [3:0]  exp_ord;
    logic [31:0] pend_res;
    logic        exec_next, h;
    int k, done, cyc;
    ops[0] = ORD_ADD; ops[1] = ORD_SUB; ops[2] = ORD_OR;
    k = 0; done = 0; cyc = 0; exec_next = 1'b0; exp_ord = IDLE_ORD; pend_res = '0;
    fp_rsp0_ready = 1'b1; fp_rsp1_ready = 1'b1;
    tick();
    fp_req0_valid = 1'b1; fp_req0_order = ops[0]; fp_req0_a = 32'd1; fp_req0_b = 32'd0;
    fp_req1_valid = 1'b1; fp_req1_order = ORD_ADD; fp_req1_a = 32'd1; fp_req1_b = 32'd1;
    while (cyc < 80 && done < 10) begin
      #1;
      n_checks++;
      if (fp_req1_ready !== 1'b0)
        $display("FAIL fp_port1_granted: got req1_ready %b at cycle %0d, want 0", fp_req1_ready, cyc);
      else n_pass++;
      n_checks++;
      if (fp_alu_order !== (exec_next ? exp_ord : IDLE_ORD))
        $display("FAIL fp_alu_order: got %b at cycle %0d, want %b", fp_alu_order, cyc,
                 exec_next ? exp_ord : IDLE_ORD);
      else n_pass++;
      if (fp_rsp0_valid) begin
        n_checks++;
        if (fp_rsp0_result !== pend_res)
          $display("FAIL fp_result: got %0d, want %0d", fp_rsp0_result, pend_res);
        else n_pass++;
      end
      h = fp_req0_valid && fp_req0_ready;
      exec_next = h;
      if (h) begin
        exp_ord  = fp_req0_order;
        pend_res = alu_fn(fp_req0_order, fp_req0_a, fp_req0_b);
      end
      tick();
      cyc++;
      if (h) begin
        done++; k++;
        if (k < 10) begin
          fp_req0_order = ops[k % 3]; fp_req0_a = 32'(k * 3 + 1); fp_req0_b = 32'(k);
        end else begin
          fp_req0_valid = 1'b0; fp_req1_valid = 1'b0;
        end
      end
    end
    n_checks++;
    if (done !== 10)
      $display("FAIL fp_count: got %0d port-0 ops, want 10 (cycle budget)", done);
    else n_pass++;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    logic h;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick();
    req0_valid = 1'b1; req0_order = ORD_ADD; req0_a = 32'd2; req0_b = 32'd2;
    tick();
    req0_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_checks++;
    if ({busy, rsp0_valid, rsp1_valid, req0_ready, req1_ready, alu_order, alu_a}
        !== {5'b0, IDLE_ORD, 32'd0})
      $display("FAIL rst_exec: got busy %b v0 %b v1 %b order %b a %0d, want 0 0 0 %b 0",
               busy, rsp0_valid, rsp1_valid, alu_order, alu_a, IDLE_ORD);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      n_checks++;
      if ({rsp0_valid, rsp1_valid} !== 2'b00)
        $display("FAIL rst_exec_no_rsp[%0d]: got v0 %b v1 %b, want 0 0", i, rsp0_valid, rsp1_valid);
      else n_pass++;
    end
    rsp0_ready = 1'b0;
    tick();
    req0_valid = 1'b1; req0_order = ORD_SUB; req0_a = 32'd5; req0_b = 32'd1;
    tick();
    req0_valid = 1'b0;
    tick();
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_checks++;
    if ({busy, rsp0_valid, rsp0_result, rsp0_zero} !== {2'b00, 32'd0, 1'b0})
      $display("FAIL rst_resp: got busy %b v0 %b res %0d z %b, want 0 0 0 0",
               busy, rsp0_valid, rsp0_result, rsp0_zero);
    else n_pass++;
    tick();
    rst_n = 1'b1; rsp0_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      n_checks++;
      if ({rsp0_valid, rsp1_valid} !== 2'b00)
        $display("FAIL rst_resp_no_rsp[%0d]: got v0 %b v1 %b, want 0 0", i, rsp0_valid, rsp1_valid);
      else n_pass++;
    end
    tick();
    req0_valid = 1'b1; req0_order = ORD_OR;  req0_a = 32'd6; req0_b = 32'd1;
    req1_valid = 1'b1; req1_order = ORD_ADD; req1_a = 32'd7; req1_b = 32'd7;
    #1;
    n_checks++;
    if ({req0_ready, req1_ready} !== 2'b10)
      $display("FAIL rst_prio: got r0 %b r1 %b, want 1 0", req0_ready, req1_ready);
    else n_pass++;
    tick();
    req0_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      h = req1_valid && req1_ready;
      tick();
      if (h) begin req1_valid = 1'b0; break; end
    end
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_req_pulse();
    test_fixed_prio();
    test_reset_mid();
    #1;
    n_checks++;
    if (exp_q.size() !== 0)
      $display("FAIL sb_drain: got %0d outstanding expected responses, want 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, want completion");
    $fatal(1);
  end

endmodule
